// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the memory stage: load/store size codes, FSM states, byte enables.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'h0;
  localparam logic [3:0] BE_BYTE = 4'h1;
  localparam logic [3:0] BE_HALF = 4'h3;
  localparam logic [3:0] BE_WORD = 4'hF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  // Lane mask for an aligned access; size taken from func3[1:0].
  function automatic logic [3:0] be_for(input logic [2:0] func, input logic [1:0] lo);
    case (func[1:0])
      2'b00:   be_for = BE_BYTE << lo;
      2'b01:   be_for = BE_HALF << {lo[1], 1'b0};
      default: be_for = BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane from a 32-bit read word and sign/zero-extends it.
module mem_load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func,
  output logic [31:0] data
);

  logic [31:0] sh;

  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    case (func)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   data = {24'h0, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   data = {16'h0, sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory request FSM (IDLE/ACCESS) plus the MEM/WB register.
// Sub-word loads/stores and misalignment detection are enabled by MEM_STAGE_SUBWORD_EN.
module mem_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic [31:0] data_for_writing_for_sw,
  input  logic [4:0]  rd_mem,
  input  logic [2:0]  func_mem,
  input  logic        mem_enable_mem,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic        wb_enable_mem,
  input  logic        ld_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misalign_err,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_en
);

  mem_state_t  state, state_nxt;
  logic        access, misalign, issue, done;
  logic [31:0] addr_req, wdata_req, load_data;
  logic [3:0]  be_req;

  assign access = mem_enable_mem & (mem_read_mem | mem_write_mem);

`ifdef MEM_STAGE_SUBWORD_EN
  always_comb begin
    case (func_mem[1:0])
      2'b00:   wdata_req = {4{data_for_writing_for_sw[7:0]}};
      2'b01:   wdata_req = {2{data_for_writing_for_sw[15:0]}};
      default: wdata_req = data_for_writing_for_sw;
    endcase
    case (func_mem[1:0])
      2'b01:   misalign = result[0];
      2'b10:   misalign = (result[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
  assign addr_req = {result[31:2], 2'b00};
  assign be_req   = be_for(func_mem, result[1:0]);

  // Upstream is frozen while the access is outstanding, so result/func_mem still describe it.
  mem_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (result[1:0]),
    .func    (func_mem),
    .data    (load_data)
  );
`else
  logic unused_func;
  assign unused_func = ^func_mem;
  assign misalign    = 1'b0;
  assign addr_req    = result;
  assign be_req      = BE_WORD;
  assign wdata_req   = data_for_writing_for_sw;
  assign load_data   = dmem_rdata;
`endif

  assign issue = (state == ST_IDLE) & access & ~misalign;
  assign done  = (state == ST_ACCESS) & dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = issue;
        if (issue) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        stall = ~dmem_ack;
        if (dmem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= BE_NONE;
      misalign_err <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_en        <= 1'b0;
    end else begin
      misalign_err <= (state == ST_IDLE) & access & misalign;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_write_mem & ~mem_read_mem;
        dmem_addr  <= addr_req;
        dmem_wdata <= wdata_req;
        dmem_be    <= be_req;
      end else if (done) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end
      // Bubble into WB while an access is being issued, waited on, or rejected as misaligned.
      if ((state == ST_IDLE && !access) || done) begin
        wb_data <= (done && ld_mem) ? load_data : result;
        wb_rd   <= rd_mem;
        wb_en   <= wb_enable_mem & (rd_mem != 5'd0);
      end else begin
        wb_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: ALU pass-through vectors, load/store handshakes, reset abort.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result, data_for_writing_for_sw, dmem_rdata;
  logic [4:0]  rd_mem;
  logic [2:0]  func_mem;
  logic        mem_enable_mem, mem_read_mem, mem_write_mem, wb_enable_mem, ld_mem, dmem_ack;
  logic        dmem_req, dmem_we, stall, misalign_err, wb_en;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        en;
  } wb_t;
  wb_t sb_q[$];

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wben;
    logic        rflag;
    logic        wflag;
    logic        exp_en;
  } alu_vec_t;
  alu_vec_t vecs[6];

  mem_stage dut (
    .clk(clk), .rst(rst), .result(result),
    .data_for_writing_for_sw(data_for_writing_for_sw), .rd_mem(rd_mem), .func_mem(func_mem),
    .mem_enable_mem(mem_enable_mem), .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .wb_enable_mem(wb_enable_mem), .ld_mem(ld_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .misalign_err(misalign_err), .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    wb_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got wb_data=0x%08h", name, wb_data);
    end else begin
      e = sb_q.pop_front();
      check({name, ".wb_data"}, wb_data, e.data);
      check({name, ".wb_rd"}, {27'h0, wb_rd}, {27'h0, e.rd});
      check({name, ".wb_en"}, {31'h0, wb_en}, {31'h0, e.en});
    end
  endtask

  task automatic drive_idle();
    mem_enable_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
    ld_mem = 1'b0; wb_enable_mem = 1'b0; rd_mem = '0; func_mem = 3'b010;
  endtask

  // Full memory transaction; called at posedge+1 with the stage idle.
  task automatic mem_op(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic wben, input logic rflag, input logic wflag,
                        input logic [2:0] func, input int delay, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    wb_t e;
    int  stall_cnt;
    logic exp_we;
    exp_we = wflag & ~rflag;
    result = addr; data_for_writing_for_sw = wdata; rd_mem = rd; wb_enable_mem = wben;
    mem_enable_mem = 1'b1; mem_read_mem = rflag; mem_write_mem = wflag; ld_mem = rflag;
    func_mem = func;
    e.data = exp_wb; e.rd = rd; e.en = wben & (rd != 5'd0);
    sb_q.push_back(e);
    #1;
    check({name, ".issue_stall"}, {31'h0, stall}, 32'd1);
    stall_cnt = 1;
    cyc();
    check({name, ".req"}, {31'h0, dmem_req}, 32'd1);
    check({name, ".we"}, {31'h0, dmem_we}, {31'h0, exp_we});
    check({name, ".be"}, {28'h0, dmem_be}, {28'h0, exp_be});
    check({name, ".wdata"}, dmem_wdata, exp_wdata);
    check({name, ".wb_en_bubble"}, {31'h0, wb_en}, 32'd0);
    for (int k = 0; k < delay; k++) begin
      check({name, ".wait_addr"}, dmem_addr, exp_addr);
      check({name, ".wait_req"}, {31'h0, dmem_req}, 32'd1);
      if (stall) stall_cnt++;
      cyc();
    end
    check({name, ".ack_addr"}, dmem_addr, exp_addr);
    check({name, ".ack_wdata"}, dmem_wdata, exp_wdata);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    #1;
    check({name, ".ack_stall"}, {31'h0, stall}, 32'd0);
    cyc();
    dmem_ack = 1'b0;
    drive_idle();
    check({name, ".req_clr"}, {31'h0, dmem_req}, 32'd0);
    check({name, ".stall_cycles"}, stall_cnt, delay + 1);
    pop_check(name);
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0; result = '0; data_for_writing_for_sw = '0;
    drive_idle();
    vecs[0] = '{32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hA5A5_A5A5, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h0BAD_F00D, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h1357_9BDF, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h2468_ACE0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1};

    #2;
    check("rst.req", {31'h0, dmem_req}, 32'd0);
    check("rst.addr", dmem_addr, 32'd0);
    check("rst.be", {28'h0, dmem_be}, 32'd0);
    check("rst.stall", {31'h0, stall}, 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.wb_en", {31'h0, wb_en}, 32'd0);
    cyc();
    rst = 1'b0;

    // ALU ops and disabled memory controls pass straight into MEM/WB.
    for (int i = 0; i < 6; i++) begin
      wb_t e;
      result = vecs[i].res; rd_mem = vecs[i].rd; wb_enable_mem = vecs[i].wben;
      mem_enable_mem = 1'b0; mem_read_mem = vecs[i].rflag; mem_write_mem = vecs[i].wflag;
      e.data = vecs[i].res; e.rd = vecs[i].rd; e.en = vecs[i].exp_en;
      sb_q.push_back(e);
      #1;
      check("alu.stall", {31'h0, stall}, 32'd0);
      cyc();
      check("alu.req", {31'h0, dmem_req}, 32'd0);
      pop_check("alu");
    end
    drive_idle();

`ifdef MEM_STAGE_SUBWORD_EN
    mem_op("lw",  32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 3, 32'hDEADBEEF,
           32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
    mem_op("sw",  32'h104, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1, 32'h0,
           32'h104, 4'hF, 32'hCAFEF00D, 32'h104);
    mem_op("lb",  32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b000, 0, 32'h80123456,
           32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    mem_op("lbu", 32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b100, 0, 32'h80123456,
           32'h100, 4'b1000, 32'h0, 32'h00000080);
    mem_op("sh",  32'h202, 32'h0000BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1, 32'h0,
           32'h200, 4'b1100, 32'hBEEFBEEF, 32'h202);
    // Misaligned halfword: no request, one-cycle error pulse, no stall.
    result = 32'h101; rd_mem = 5'd6; wb_enable_mem = 1'b1; func_mem = 3'b001;
    mem_enable_mem = 1'b1; mem_read_mem = 1'b1; ld_mem = 1'b1;
    #1;
    check("lh_mis.stall", {31'h0, stall}, 32'd0);
    cyc();
    drive_idle();
    check("lh_mis.err", {31'h0, misalign_err}, 32'd1);
    check("lh_mis.req", {31'h0, dmem_req}, 32'd0);
    check("lh_mis.wb_en", {31'h0, wb_en}, 32'd0);
    cyc();
    check("lh_mis.err_clr", {31'h0, misalign_err}, 32'd0);
`else
    mem_op("lw",  32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 3, 32'hDEADBEEF,
           32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
    mem_op("sw",  32'h104, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1, 32'h0,
           32'h104, 4'hF, 32'hCAFEF00D, 32'h104);
    mem_op("lb_ignored", 32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b000, 0, 32'h80123456,
           32'h103, 4'hF, 32'h0, 32'h80123456);
    check("no_mis.err", {31'h0, misalign_err}, 32'd0);
`endif
    mem_op("lw_rd0", 32'h108, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 3'b010, 0, 32'h55AA55AA,
           32'h108, 4'hF, 32'h0, 32'h55AA55AA);
    mem_op("rw_both", 32'h10C, 32'h11111111, 5'd8, 1'b1, 1'b1, 1'b1, 3'b010, 2, 32'h76543210,
           32'h10C, 4'hF, 32'h11111111, 32'h76543210);

    // Reset mid-access abandons it; the late ack in IDLE must be ignored.
    result = 32'h300; rd_mem = 5'd9; wb_enable_mem = 1'b1; mem_enable_mem = 1'b1;
    mem_read_mem = 1'b1; ld_mem = 1'b1;
    cyc();
    check("rstacc.req", {31'h0, dmem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstacc.req0", {31'h0, dmem_req}, 32'd0);
    check("rstacc.addr0", dmem_addr, 32'd0);
    check("rstacc.stall0", {31'h0, stall}, 32'd0);
    check("rstacc.wb_en0", {31'h0, wb_en}, 32'd0);
    drive_idle();
    cyc();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;
    #1;
    check("late_ack.stall", {31'h0, stall}, 32'd0);
    cyc();
    dmem_ack = 1'b0;
    check("late_ack.req", {31'h0, dmem_req}, 32'd0);
    check("late_ack.wb_en", {31'h0, wb_en}, 32'd0);
    check("late_ack.sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
